n4_mfr_controller: RTL and testbench

- Sequencer for the 4-bit multifunction register (function select b, operand x3_x0, output z3_z0).
- Holds a small program of up to P steps. Each step is {function select, 4-bit operand, last flag}.
- On a soc/eoc handshake it runs the program one step per clock against an embedded register datapath, then holds the result.
- Sits between a host that loads programs and starts runs, and the register it configures.

---
 rtl/n4_mfr_pkg.sv | 51 +++++
 rtl/n4_mfr_datapath.sv | 37 +++
 rtl/n4_mfr_controller.sv | 105 ++++++++++
 tb/tb_n4_mfr_controller.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/n4_mfr_pkg.sv
// Shared definitions for the 4-bit multifunction register sequencer:
// function-select codes, step-word layout, FSM states and the register update rule.
package n4_mfr_pkg;

  typedef enum logic [1:0] {
    F_LOAD = 2'd0,
    F_ADD  = 2'd1,
    F_SHL  = 2'd2,
    F_XOR  = 2'd3
  } func_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    RUN  = 2'd2
  } state_e;

  localparam int STEP_W   = 7;
  localparam int B_HI     = 6;
  localparam int B_LO     = 5;
  localparam int X_HI     = 4;
  localparam int X_LO     = 1;
  localparam int LAST_BIT = 0;

  typedef struct packed {
    logic [1:0] b;
    logic [3:0] x;
    logic       last;
  } step_t;

  // Cleared program entries load zero and terminate the run immediately.
  localparam step_t STEP_RESET = '{b: 2'd0, x: 4'd0, last: 1'b1};

  // Returns {cy, OUTR} after applying function b with operand x.
  function automatic logic [4:0] mfr_apply(input logic [1:0] b,
                                           input logic [3:0] z,
                                           input logic       cy,
                                           input logic [3:0] x);
    logic [4:0] result;
    result = {cy, z};
    case (func_e'(b))
      F_LOAD:  result = {cy, x};
      F_ADD:   result = {1'b0, z} + {1'b0, x};
      F_SHL:   result = {z[3], z[2:0], x[0]};
      F_XOR:   result = {cy, z ^ x};
      default: result = {cy, z};
    endcase
    return result;
  endfunction

endpackage

// File: rtl/n4_mfr_datapath.sv
// The 4-bit multifunction register itself: OUTR and the carry flag,
// updated only on enabled cycles.
module n4_mfr_datapath
  import n4_mfr_pkg::*;
(
  input  logic       clock,
  input  logic       reset_,
  input  logic       en,
  input  logic       clr_cy,
  input  logic [1:0] b,
  input  logic [3:0] x3_x0,
  output logic [3:0] z3_z0,
  output logic       cy
);

  logic [3:0] r_z;
  logic       r_cy;
  logic [4:0] w_result;

  assign w_result = mfr_apply(b, r_z, r_cy, x3_x0);

  // clr_cy only arrives on a run start, never together with en.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      r_z  <= 4'd0;
      r_cy <= 1'b0;
    end else if (en) begin
      {r_cy, r_z} <= w_result;
    end else if (clr_cy) begin
      r_cy <= 1'b0;
    end
  end

  assign z3_z0 = r_z;
  assign cy    = r_cy;

endmodule

// File: rtl/n4_mfr_controller.sv
// Program store and soc/eoc sequencer that steps a loaded program
// through the multifunction register datapath one step per clock.
module n4_mfr_controller
  import n4_mfr_pkg::*;
#(
  parameter  int P  = 8,
  localparam int AW = $clog2(P)
) (
  input  logic              clock,
  input  logic              reset_,
  input  logic              prog_we,
  input  logic [AW-1:0]     prog_addr,
  input  logic [STEP_W-1:0] prog_data,
  input  logic              soc,
  output logic              eoc,
  output logic [3:0]        z3_z0,
  output logic              cy
);

  state_e        r_state;
  state_e        w_next_state;
  logic [AW-1:0] r_pc;
  logic [AW-1:0] w_pc_next;
  step_t         r_prog [P];
  step_t         w_step;
  step_t         w_wr_step;
  logic          w_last_step;
  logic          w_dp_en;
  logic          w_clr_cy;

  assign w_wr_step = '{b:    prog_data[B_HI:B_LO],
                       x:    prog_data[X_HI:X_LO],
                       last: prog_data[LAST_BIT]};

  assign w_step      = r_prog[r_pc];
  assign w_last_step = w_step.last || (r_pc == AW'(P - 1));

  // The program may only change while idle so a run always sees a stable program.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      for (int i = 0; i < P; i++) begin
        r_prog[i] <= STEP_RESET;
      end
    end else if (prog_we && (r_state == IDLE)) begin
      r_prog[prog_addr] <= w_wr_step;
    end
  end

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      r_state <= IDLE;
      r_pc    <= '0;
    end else begin
      r_state <= w_next_state;
      r_pc    <= w_pc_next;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_pc_next    = r_pc;
    w_dp_en      = 1'b0;
    w_clr_cy     = 1'b0;
    case (r_state)
      IDLE: begin
        if (soc) begin
          w_next_state = ACK;
          w_pc_next    = '0;
          w_clr_cy     = 1'b1;
        end
      end
      ACK: begin
        if (!soc) begin
          w_next_state = RUN;
        end
      end
      RUN: begin
        w_dp_en = 1'b1;
        if (w_last_step) begin
          w_next_state = IDLE;
        end else begin
          w_pc_next = r_pc + AW'(1);
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Registered state makes eoc rise on the same edge as the final step.
  assign eoc = (r_state == IDLE);

  n4_mfr_datapath u_datapath (
    .clock  (clock),
    .reset_ (reset_),
    .en     (w_dp_en),
    .clr_cy (w_clr_cy),
    .b      (w_step.b),
    .x3_x0  (w_step.x),
    .z3_z0  (z3_z0),
    .cy     (cy)
  );

endmodule

// File: tb/tb_n4_mfr_controller.sv
// Directed testbench for n4_mfr_controller: programs small step lists,
// runs them through the soc/eoc handshake and checks hand-computed results.
module tb_n4_mfr_controller;

  logic       clock;
  logic       reset_;
  logic       prog_we;
  logic [2:0] prog_addr;
  logic [6:0] prog_data;
  logic       soc;
  logic       eoc;
  logic [3:0] z3_z0;
  logic       cy;

  int errors = 0;
  int checks = 0;
  int n;

  n4_mfr_controller #(.P(8)) dut (
    .clock     (clock),
    .reset_    (reset_),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .soc       (soc),
    .eoc       (eoc),
    .z3_z0     (z3_z0),
    .cy        (cy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Writes one program step; called at a negedge while idle.
  task automatic applyStimulus(input logic [2:0] a, input logic [1:0] b,
                               input logic [3:0] x, input logic last);
    prog_we   = 1'b1;
    prog_addr = a;
    prog_data = {b, x, last};
    @(negedge clock);
    prog_we   = 1'b0;
  endtask

  // soc pulse for one edge; returns at the negedge after the IDLE->ACK edge.
  task automatic startRun();
    soc = 1'b1;
    @(negedge clock);
    soc = 1'b0;
  endtask

  // Called in ACK with soc low; returns number of RUN cycles, or -1 on timeout.
  task automatic waitDone(input int maxCycles, output int runCycles);
    runCycles = -1;
    for (int i = 1; i <= maxCycles; i++) begin
      @(negedge clock);
      if (eoc === 1'b1) begin
        runCycles = i - 1;
        break;
      end
    end
  endtask

  task automatic checkResult(input string tag, input int cyc, input int expCyc,
                             input logic [3:0] expZ, input logic expCy);
    checkOutput({tag, "_cycles"}, 8'(cyc), 8'(expCyc));
    checkOutput({tag, "_eoc"}, {7'd0, eoc}, 8'd1);
    checkOutput({tag, "_z"}, {4'd0, z3_z0}, {4'd0, expZ});
    checkOutput({tag, "_cy"}, {7'd0, cy}, {7'd0, expCy});
  endtask

  initial begin
    reset_    = 1'b0;
    soc       = 1'b0;
    prog_we   = 1'b0;
    prog_addr = 3'd0;
    prog_data = 7'd0;
    repeat (2) @(negedge clock);
    checkOutput("reset_eoc", {7'd0, eoc}, 8'd1);
    checkOutput("reset_z", {4'd0, z3_z0}, 8'd0);
    checkOutput("reset_cy", {7'd0, cy}, 8'd0);
    reset_ = 1'b1;
    @(negedge clock);

    // load 9; add 9 (last) -> 18 -> z=2, cy=1
    applyStimulus(3'd0, 2'd0, 4'd9, 1'b0);
    applyStimulus(3'd1, 2'd1, 4'd9, 1'b1);
    startRun();
    waitDone(40, n);
    checkResult("pre", n, 2, 4'd2, 1'b1);

    // Asynchronous reset between clock edges
    #2 reset_ = 1'b0;
    #1;
    checkOutput("async_rst_eoc", {7'd0, eoc}, 8'd1);
    checkOutput("async_rst_z", {4'd0, z3_z0}, 8'd0);
    checkOutput("async_rst_cy", {7'd0, cy}, 8'd0);
    @(negedge clock);
    reset_ = 1'b1;

    // Cleared program: load 0, ends after one cycle
    startRun();
    waitDone(40, n);
    checkResult("cleared", n, 1, 4'd0, 1'b0);

    // load 5; add 9; add 3 (last): 5, 14, 1 with carry
    applyStimulus(3'd0, 2'd0, 4'd5, 1'b0);
    applyStimulus(3'd1, 2'd1, 4'd9, 1'b0);
    applyStimulus(3'd2, 2'd1, 4'd3, 1'b1);
    startRun();
    checkOutput("add_ack_eoc", {7'd0, eoc}, 8'd0);
    @(negedge clock);
    checkOutput("add_run0_z", {4'd0, z3_z0}, 8'd0);
    @(negedge clock);
    checkOutput("add_step1_z", {4'd0, z3_z0}, 8'd5);
    checkOutput("add_step1_eoc", {7'd0, eoc}, 8'd0);
    @(negedge clock);
    checkOutput("add_step2_z", {4'd0, z3_z0}, 8'd14);
    checkOutput("add_step2_cy", {7'd0, cy}, 8'd0);
    checkOutput("add_step2_eoc", {7'd0, eoc}, 8'd0);
    @(negedge clock);
    checkOutput("add_final_z", {4'd0, z3_z0}, 8'd1);
    checkOutput("add_final_cy", {7'd0, cy}, 8'd1);
    checkOutput("add_final_eoc", {7'd0, eoc}, 8'd1);

    // Run start clears cy; load leaves it cleared
    applyStimulus(3'd0, 2'd0, 4'd3, 1'b1);
    startRun();
    waitDone(40, n);
    checkResult("cyclear", n, 1, 4'd3, 1'b0);

    // load 1001; shl x=1 -> 0011 cy=1; xor 1111 -> 1100
    applyStimulus(3'd0, 2'd0, 4'b1001, 1'b0);
    applyStimulus(3'd1, 2'd2, 4'd1, 1'b0);
    applyStimulus(3'd2, 2'd3, 4'b1111, 1'b1);
    startRun();
    waitDone(40, n);
    checkResult("shlxor", n, 3, 4'b1100, 1'b1);

    // No last flag: eight add-1 steps from 12 -> 20 mod 16 = 4, last add no carry
    for (int i = 0; i < 8; i++) begin
      applyStimulus(3'(i), 2'd1, 4'd1, 1'b0);
    end
    startRun();
    waitDone(40, n);
    checkResult("wrap", n, 8, 4'd4, 1'b0);

    // soc held for 5 cycles keeps the controller in ACK
    applyStimulus(3'd0, 2'd0, 4'd6, 1'b1);
    soc = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      checkOutput("hold_eoc", {7'd0, eoc}, 8'd0);
      checkOutput("hold_z", {4'd0, z3_z0}, 8'd4);
    end
    soc = 1'b0;
    waitDone(40, n);
    checkResult("hold", n, 1, 4'd6, 1'b0);

    // prog_we during ACK/RUN must not alter the program
    applyStimulus(3'd0, 2'd0, 4'd1, 1'b0);
    applyStimulus(3'd1, 2'd1, 4'd1, 1'b0);
    applyStimulus(3'd2, 2'd1, 4'd1, 1'b0);
    applyStimulus(3'd3, 2'd1, 4'd1, 1'b1);
    startRun();
    prog_we   = 1'b1;
    prog_addr = 3'd0;
    prog_data = {2'd0, 4'hF, 1'b1};
    waitDone(40, n);
    prog_we = 1'b0;
    checkResult("wedrun", n, 4, 4'd4, 1'b0);
    startRun();
    waitDone(40, n);
    checkResult("wedrun_again", n, 4, 4'd4, 1'b0);

    // Reset in the middle of a run
    startRun();
    @(negedge clock);
    @(negedge clock);
    @(negedge clock);
    checkOutput("midrun_z", {4'd0, z3_z0}, 8'd2);
    checkOutput("midrun_eoc", {7'd0, eoc}, 8'd0);
    #2 reset_ = 1'b0;
    #1;
    checkOutput("midrst_eoc", {7'd0, eoc}, 8'd1);
    checkOutput("midrst_z", {4'd0, z3_z0}, 8'd0);
    checkOutput("midrst_cy", {7'd0, cy}, 8'd0);
    @(negedge clock);
    reset_ = 1'b1;
    startRun();
    waitDone(40, n);
    checkResult("midrst_cleared", n, 1, 4'd0, 1'b0);

    // Fresh program after reset: load 10; add 7 (last) -> 17 -> z=1, cy=1
    applyStimulus(3'd0, 2'd0, 4'd10, 1'b0);
    applyStimulus(3'd1, 2'd1, 4'd7, 1'b1);
    startRun();
    waitDone(40, n);
    checkResult("fresh", n, 2, 4'd1, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
